// File: rtl/thread_register_file.sv
// Per-thread register file with three read-only identity registers and
// optional deferred load writeback (enabled by REGFILE_DEFERRED_WB_EN).
module thread_register_file #(
   parameter int BLOCK_ID  = 0,
   parameter int THREAD_ID = 0,
   parameter int DATA_BITS = 8,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           block_dim,
   input  logic [2:0]           core_state,
   input  logic                 decoded_reg_write_enable,
   input  logic [1:0]           decoded_reg_input_mux,
   input  logic [ADDR_BITS-1:0] decoded_rd_address,
   input  logic [ADDR_BITS-1:0] decoded_rs_address,
   input  logic [ADDR_BITS-1:0] decoded_rt_address,
   input  logic [DATA_BITS-1:0] decoded_immediate,
   input  logic [DATA_BITS-1:0] alu_out,
   input  logic [DATA_BITS-1:0] lsu_out,
   input  logic                 lsu_wb_valid,
   input  logic [ADDR_BITS-1:0] lsu_wb_address,
   input  logic [DATA_BITS-1:0] lsu_wb_data,
   output logic [DATA_BITS-1:0] rs,
   output logic [DATA_BITS-1:0] rt,
   output logic                 operand_hazard,
   output logic                 lsu_pending
);

   localparam int NUM_REGS = 2 ** ADDR_BITS;
   localparam int W_TOP    = NUM_REGS - 3;
   localparam logic [2:0] REQUEST = 3'b011;
   localparam logic [2:0] UPDATE  = 3'b110;

   typedef enum logic [1:0] {
      SRC_ARITH = 2'b00,
      SRC_MEM   = 2'b01,
      SRC_CONST = 2'b10,
      SRC_DEFER = 2'b11
   } src_e;

   logic [DATA_BITS-1:0] regs [W_TOP];
   logic [DATA_BITS-1:0] view [NUM_REGS];
   logic [DATA_BITS-1:0] bd_q;
   logic [DATA_BITS-1:0] write_src;
   logic [NUM_REGS-1:0]  pend_full;
   logic                 upd_en;
   logic                 upd_data_en;
   logic                 wb_en;
   logic                 rs_pend, rt_pend, rs_byp, rt_byp;

   // block_dim is refreshed every cycle, reset included
   always_ff @(posedge clk) begin
      bd_q <= DATA_BITS'(block_dim);
   end

   always_comb begin
      for (int i = 0; i < W_TOP; i++) view[i] = regs[i];
      view[NUM_REGS-3] = DATA_BITS'(BLOCK_ID);
      view[NUM_REGS-2] = bd_q;
      view[NUM_REGS-1] = DATA_BITS'(THREAD_ID);
   end

   always_comb begin
      write_src = alu_out;
      case (src_e'(decoded_reg_input_mux))
         SRC_ARITH: write_src = alu_out;
         SRC_MEM:   write_src = lsu_out;
         SRC_CONST: write_src = decoded_immediate;
         default:   write_src = alu_out;
      endcase
   end

   assign upd_en      = (core_state == REQUEST ? 1'b0 : core_state == UPDATE)
                        && decoded_reg_write_enable
                        && (decoded_rd_address < ADDR_BITS'(W_TOP));
   assign upd_data_en = upd_en && (decoded_reg_input_mux != SRC_DEFER);
   // Only a pending (hence writable) register accepts a load return
   assign wb_en       = lsu_wb_valid && pend_full[lsu_wb_address];

   // A non-deferred UPDATE to the same register overrides a simultaneous return
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < W_TOP; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < W_TOP; i++) begin
            if (upd_data_en && decoded_rd_address == ADDR_BITS'(i))
               regs[i] <= write_src;
            else if (wb_en && lsu_wb_address == ADDR_BITS'(i))
               regs[i] <= lsu_wb_data;
         end
      end
   end

`ifdef REGFILE_DEFERRED_WB_EN
   logic [W_TOP-1:0] pending;

   // A DEFERRED UPDATE keeps the bit set even if an older load returns now
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
      end else begin
         for (int i = 0; i < W_TOP; i++) begin
            if (upd_en && decoded_rd_address == ADDR_BITS'(i))
               pending[i] <= (decoded_reg_input_mux == SRC_DEFER);
            else if (wb_en && lsu_wb_address == ADDR_BITS'(i))
               pending[i] <= 1'b0;
         end
      end
   end

   assign pend_full = {3'b000, pending};
`else
   assign pend_full = '0;
`endif

   always_comb begin
      rs_pend = pend_full[decoded_rs_address];
      rt_pend = pend_full[decoded_rt_address];
      rs_byp  = rs_pend && lsu_wb_valid && (lsu_wb_address == decoded_rs_address);
      rt_byp  = rt_pend && lsu_wb_valid && (lsu_wb_address == decoded_rt_address);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rs             <= '0;
         rt             <= '0;
         operand_hazard <= 1'b0;
      end else if (core_state == REQUEST) begin
         rs             <= rs_byp ? lsu_wb_data : view[decoded_rs_address];
         rt             <= rt_byp ? lsu_wb_data : view[decoded_rt_address];
         operand_hazard <= (rs_pend && !rs_byp) || (rt_pend && !rt_byp);
      end
   end

   assign lsu_pending = |pend_full;

endmodule

// File: tb/tb_thread_register_file.sv
// Scoreboard bench for thread_register_file; expectations follow the
// REGFILE_DEFERRED_WB_EN setting the design is built with.
module tb_thread_register_file;

`ifdef REGFILE_DEFERRED_WB_EN
   localparam bit DEF = 1'b1;
`else
   localparam bit DEF = 1'b0;
`endif

   localparam logic [2:0] IDLE = 3'b000, REQ = 3'b011, UPD = 3'b110;
   localparam logic [1:0] M_AR = 2'b00, M_MEM = 2'b01, M_CON = 2'b10, M_DEF = 2'b11;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] block_dim;
   logic [2:0] core_state;
   logic       we;
   logic [1:0] mux;
   logic [3:0] rd_a, rs_a, rt_a;
   logic [7:0] imm, alu, lsu;
   logic       wb_v;
   logic [3:0] wb_a;
   logic [7:0] wb_d;
   logic [7:0] rs, rt;
   logic       operand_hazard, lsu_pending;

   typedef struct {
      string      name;
      logic [7:0] rs;
      logic [7:0] rt;
      logic       hz;
      logic       pend;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;

   thread_register_file #(.BLOCK_ID(2), .THREAD_ID(3), .DATA_BITS(8), .ADDR_BITS(4)) dut (
      .clk(clk), .reset(reset), .block_dim(block_dim), .core_state(core_state),
      .decoded_reg_write_enable(we), .decoded_reg_input_mux(mux),
      .decoded_rd_address(rd_a), .decoded_rs_address(rs_a), .decoded_rt_address(rt_a),
      .decoded_immediate(imm), .alu_out(alu), .lsu_out(lsu),
      .lsu_wb_valid(wb_v), .lsu_wb_address(wb_a), .lsu_wb_data(wb_d),
      .rs(rs), .rt(rt), .operand_hazard(operand_hazard), .lsu_pending(lsu_pending)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] want);
      checks++;
      if (act === want) passes++;
      else $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, want);
   endtask

   // One clock of stimulus; only the source selected by mux carries the value
   task automatic applyStimulus(input logic [2:0] st, input logic w, input logic [1:0] m,
                                input logic [3:0] rd, input logic [3:0] sa, input logic [3:0] ta,
                                input logic [7:0] d, input logic v, input logic [3:0] va,
                                input logic [7:0] vd);
      core_state = st; we = w; mux = m; rd_a = rd; rs_a = sa; rt_a = ta;
      imm = (m == M_CON) ? d : ~d;
      alu = (m == M_AR)  ? d : ~d;
      lsu = (m == M_MEM) ? d : ~d;
      wb_v = v; wb_a = va; wb_d = vd;
      @(posedge clk); #1;
      core_state = IDLE; we = 1'b0; wb_v = 1'b0;
   endtask

   task automatic upd(input logic [1:0] m, input logic [3:0] rd, input logic [7:0] d);
      applyStimulus(UPD, 1'b1, m, rd, 4'd0, 4'd0, d, 1'b0, 4'd0, 8'h00);
   endtask

   task automatic ret(input logic [3:0] a, input logic [7:0] d);
      applyStimulus(IDLE, 1'b0, M_AR, 4'd0, 4'd0, 4'd0, 8'h00, 1'b1, a, d);
   endtask

   task automatic request(input string name, input logic [3:0] sa, input logic [3:0] ta,
                          input logic [7:0] ers, input logic [7:0] ert, input logic ehz,
                          input logic epd, input logic v, input logic [3:0] va, input logic [7:0] vd);
      exp_t e;
      e.name = name; e.rs = ers; e.rt = ert; e.hz = ehz; e.pend = epd;
      exp_q.push_back(e);
      applyStimulus(REQ, 1'b0, M_AR, 4'd0, sa, ta, 8'h00, v, va, vd);
   endtask

   // Monitor: after every REQUEST edge pop and compare; otherwise outputs must hold
   logic req_q = 1'b0, rst_q = 1'b0;
   exp_t last;
   bit   have_last = 1'b0;

   always @(posedge clk) begin
      req_q <= (core_state == REQ) && !reset;
      rst_q <= reset;
   end

   always @(negedge clk) begin
      if (rst_q) begin
         last.name = "reset"; last.rs = 8'h00; last.rt = 8'h00; last.hz = 1'b0; last.pend = 1'b0;
         have_last = 1'b1;
      end
      if (req_q) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_request: got output with empty queue, expected none");
         end else begin
            last = exp_q.pop_front();
            have_last = 1'b1;
            checkOutput({last.name, "_rs"}, rs, last.rs);
            checkOutput({last.name, "_rt"}, rt, last.rt);
            checkOutput({last.name, "_hazard"}, {7'd0, operand_hazard}, {7'd0, last.hz});
            checkOutput({last.name, "_pending"}, {7'd0, lsu_pending}, {7'd0, last.pend});
         end
      end else if (have_last) begin
         checkOutput("hold_rs", rs, last.rs);
         checkOutput("hold_rt", rt, last.rt);
         checkOutput("hold_hazard", {7'd0, operand_hazard}, {7'd0, last.hz});
      end
   end

   initial begin
      reset = 1'b1; block_dim = 8'h20; core_state = IDLE; we = 1'b0; mux = M_AR;
      rd_a = 4'd0; rs_a = 4'd0; rt_a = 4'd0; imm = 8'h00; alu = 8'h00; lsu = 8'h00;
      wb_v = 1'b0; wb_a = 4'd0; wb_d = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      checkOutput("reset_rs", rs, 8'h00);
      checkOutput("reset_rt", rt, 8'h00);
      checkOutput("reset_hazard", {7'd0, operand_hazard}, 8'h00);
      checkOutput("reset_pending", {7'd0, lsu_pending}, 8'h00);

      request("ident", 4'd13, 4'd15, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

      upd(M_CON, 4'd4, 8'h5A);
      request("const_r4", 4'd4, 4'd14, 8'h5A, 8'h20, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      upd(M_CON, 4'd14, 8'h77);
      request("ro_r14", 4'd14, 4'd13, 8'h20, 8'h02, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      upd(M_MEM, 4'd5, 8'h3C);
      upd(M_AR, 4'd3, 8'h81);
      applyStimulus(UPD, 1'b0, M_CON, 4'd4, 4'd0, 4'd0, 8'hFF, 1'b0, 4'd0, 8'h00);
      applyStimulus(3'b010, 1'b1, M_CON, 4'd4, 4'd0, 4'd0, 8'hEE, 1'b0, 4'd0, 8'h00);
      request("mem_arith", 4'd5, 4'd3, 8'h3C, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      request("no_write", 4'd4, 4'd4, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

      upd(M_DEF, 4'd6, 8'h00);
      request("haz_rt", 4'd4, 4'd6, 8'h5A, 8'h00, DEF, DEF, 1'b0, 4'd0, 8'h00);
      request("haz_rs", 4'd6, 4'd4, 8'h00, 8'h5A, DEF, DEF, 1'b0, 4'd0, 8'h00);
      ret(4'd6, 8'h33);
      request("ret_r6", 4'd6, 4'd6, DEF ? 8'h33 : 8'h00, DEF ? 8'h33 : 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

      upd(M_DEF, 4'd7, 8'h00);
      request("bypass_r7", 4'd7, 4'd4, DEF ? 8'h44 : 8'h00, 8'h5A, 1'b0, 1'b0, 1'b1, 4'd7, 8'h44);
      request("after_byp", 4'd7, 4'd5, DEF ? 8'h44 : 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

      upd(M_DEF, 4'd8, 8'h00);
      applyStimulus(UPD, 1'b1, M_AR, 4'd8, 4'd0, 4'd0, 8'h10, 1'b1, 4'd8, 8'h99);
      request("waw_r8", 4'd8, 4'd8, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      ret(4'd8, 8'hEE);
      request("drop_r8", 4'd8, 4'd4, 8'h10, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

      upd(M_DEF, 4'd10, 8'h00);
      applyStimulus(UPD, 1'b1, M_DEF, 4'd10, 4'd0, 4'd0, 8'h00, 1'b1, 4'd10, 8'h66);
      request("redefer_r10", 4'd10, 4'd10, DEF ? 8'h66 : 8'h00, DEF ? 8'h66 : 8'h00, DEF, DEF, 1'b0, 4'd0, 8'h00);
      ret(4'd10, 8'h67);
      request("ret_r10", 4'd10, 4'd4, DEF ? 8'h67 : 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

      upd(M_DEF, 4'd11, 8'h00);
      applyStimulus(UPD, 1'b1, M_CON, 4'd12, 4'd0, 4'd0, 8'h12, 1'b1, 4'd11, 8'h11);
      request("split_wb", 4'd11, 4'd12, DEF ? 8'h11 : 8'h00, 8'h12, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      ret(4'd4, 8'hFF);
      upd(M_DEF, 4'd13, 8'h00);
      request("ro_defer", 4'd13, 4'd4, 8'h02, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

      upd(M_DEF, 4'd9, 8'h00);
      request("pend_r9", 4'd9, 4'd9, 8'h00, 8'h00, DEF, DEF, 1'b0, 4'd0, 8'h00);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      ret(4'd9, 8'h55);
      request("post_reset", 4'd9, 4'd4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

      repeat (2) @(posedge clk);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         $display("[TB] FAIL drain: got %0d outstanding, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
